multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller_pkg.sv | 70 +++++++
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/multicycle_controller_imm_src_decoder.sv | 21 ++
 rtl/multicycle_controller.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states and datapath mux codes.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALUA_PC    = 2'b00;
    localparam logic [1:0] ALUA_OLDPC = 2'b01;
    localparam logic [1:0] ALUA_RS1   = 2'b10;
    localparam logic [1:0] ALUA_ZERO  = 2'b11;

    localparam logic [1:0] ALUB_RS2  = 2'b00;
    localparam logic [1:0] ALUB_IMM  = 2'b01;
    localparam logic [1:0] ALUB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // DECODE successor; S_TRAP doubles as the "unknown opcode" marker.
    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return S_EXECR;
            OP_ITYPE:          return S_EXECI;
            OP_BRANCH:         return S_BEQ;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            OP_AUIPC:          return S_AUIPC;
            default:           return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle; slave is the controller side.
interface multicycle_controller_if #(parameter int STATE_W = 4);

    logic [6:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               MemWrite;
    logic               AdrSrc;
    logic               IRWrite;
    logic               PCWrite;
    logic               RegWrite;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [2:0]         ImmSrc;
    logic               illegal;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        output op, zero, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, state_dbg
    );

    modport slave (
        input  op, zero, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, state_dbg
    );

endinterface

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Immediate-format select from the opcode; shared with the pipelined core.
module imm_src_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    // Opcode to immediate format; unknown opcodes fall back to I-type.
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:         imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: Moore outputs per state, FETCH/BEQ strobes qualified by rdy/zero.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_HANDSHAKE   = 1,
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int STATE_W         = 4
)(
    input logic                    clk,
    input logic                    rst_n,
    multicycle_controller_if.slave bus
);

    state_t     state_r;
    state_t     next_s;
    logic       illegal_r;
    logic       illegal_next_s;
    logic       rdy_s;
    logic       mem_req_s;
    logic       mem_write_s;
    logic       adr_src_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [2:0] imm_src_s;

    assign rdy_s = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

    imm_src_decoder u_imm_src_decoder (
        .op      (bus.op),
        .imm_src (imm_src_s)
    );

    // State and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= next_s;
            illegal_r <= illegal_next_s;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        next_s         = state_r;
        illegal_next_s = illegal_r;
        mem_req_s      = 1'b0;
        mem_write_s    = 1'b0;
        adr_src_s      = 1'b0;
        ir_write_s     = 1'b0;
        pc_write_s     = 1'b0;
        reg_write_s    = 1'b0;
        result_src_s   = RES_ALUOUT;
        alu_src_a_s    = ALUA_PC;
        alu_src_b_s    = ALUB_RS2;
        alu_op_s       = ALUOP_ADD;
        case (state_r)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = ALUB_FOUR;
                result_src_s = RES_ALURESULT;
                if (rdy_s) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    next_s     = S_DECODE;
                end else begin
                    next_s     = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a_s = ALUA_OLDPC;
                alu_src_b_s = ALUB_IMM;
                if (decode_next(bus.op) != S_TRAP) begin
                    next_s = decode_next(bus.op);
                end else if (TRAP_ON_ILLEGAL != 0) begin
                    next_s         = S_TRAP;
                    illegal_next_s = 1'b1;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a_s = ALUA_RS1;
                alu_src_b_s = ALUB_IMM;
                if (bus.op == OP_LOAD) begin
                    next_s = S_MEMREAD;
                end else begin
                    next_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (rdy_s) begin
                    next_s = S_MEMWB;
                end else begin
                    next_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
                next_s       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (rdy_s) begin
                    next_s = S_FETCH;
                end else begin
                    next_s = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                alu_src_a_s = ALUA_RS1;
                alu_src_b_s = ALUB_RS2;
                alu_op_s    = ALUOP_FUNCT;
                next_s      = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s = ALUA_RS1;
                alu_src_b_s = ALUB_IMM;
                alu_op_s    = ALUOP_FUNCT;
                next_s      = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a_s = ALUA_ZERO;
                alu_src_b_s = ALUB_IMM;
                next_s      = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a_s = ALUA_OLDPC;
                alu_src_b_s = ALUB_IMM;
                next_s      = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_s = RES_ALUOUT;
                reg_write_s  = 1'b1;
                next_s       = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_s  = ALUA_RS1;
                alu_src_b_s  = ALUB_RS2;
                alu_op_s     = ALUOP_SUB;
                result_src_s = RES_ALUOUT;
                pc_write_s   = bus.zero;
                next_s       = S_FETCH;
            end
            S_JALR: begin
                alu_src_a_s = ALUA_RS1;
                alu_src_b_s = ALUB_IMM;
                next_s      = S_JAL;
            end
            S_JAL: begin
                // ALUOut already holds the target; ALU computes the link value OldPC+4.
                alu_src_a_s  = ALUA_OLDPC;
                alu_src_b_s  = ALUB_FOUR;
                result_src_s = RES_ALUOUT;
                pc_write_s   = 1'b1;
                next_s       = S_ALUWB;
            end
            S_TRAP: begin
                next_s = S_TRAP;
            end
            default: begin
                next_s = S_FETCH;
            end
        endcase
    end

    // Reset forces strobes and selects low even though FETCH would request memory.
    assign bus.mem_req   = rst_n & mem_req_s;
    assign bus.MemWrite  = rst_n & mem_write_s;
    assign bus.AdrSrc    = rst_n & adr_src_s;
    assign bus.IRWrite   = rst_n & ir_write_s;
    assign bus.PCWrite   = rst_n & pc_write_s;
    assign bus.RegWrite  = rst_n & reg_write_s;
    assign bus.ResultSrc = rst_n ? result_src_s : 2'b00;
    assign bus.ALUSrcA   = rst_n ? alu_src_a_s  : 2'b00;
    assign bus.ALUSrcB   = rst_n ? alu_src_b_s  : 2'b00;
    assign bus.ALUOp     = rst_n ? alu_op_s     : 2'b00;
    assign bus.ImmSrc    = imm_src_s;
    assign bus.illegal   = illegal_r;
    assign bus.state_dbg = STATE_W'(state_r);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: dut_a (handshake, trap) and dut_b (no handshake, illegal as NOP).
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic clk = 1'b0;
    logic rst_na;
    logic rst_nb;

    always #5 clk = ~clk;

    multicycle_controller_if #(.STATE_W(4)) ifa ();
    multicycle_controller_if #(.STATE_W(4)) ifb ();

    multicycle_controller #(.MEM_HANDSHAKE(1), .TRAP_ON_ILLEGAL(1), .STATE_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_na),
        .bus   (ifa)
    );

    multicycle_controller #(.MEM_HANDSHAKE(0), .TRAP_ON_ILLEGAL(0), .STATE_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (ifb)
    );

    // strb = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite}; chk[0] = rs/aop, chk[1] = imm
    typedef struct {
        logic [6:0] op;
        logic       mr;
        logic       zr;
        logic [3:0] st;
        logic [4:0] strb;
        logic       ill;
        logic [1:0] rs;
        logic [1:0] aop;
        logic [2:0] imm;
        logic [1:0] chk;
    } item_t;

    typedef struct packed {
        logic [3:0] st;
        logic [4:0] strb;
        logic       ill;
        logic [1:0] rs;
        logic [1:0] aop;
        logic [2:0] imm;
    } obs_t;

    item_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic add(input logic [6:0] op, input logic mr, input logic zr, input logic [3:0] st,
                       input logic [4:0] strb, input logic ill, input logic [1:0] rs,
                       input logic [1:0] aop, input logic [2:0] imm, input logic [1:0] chk);
        item_t it;
        it.op = op; it.mr = mr; it.zr = zr; it.st = st; it.strb = strb;
        it.ill = ill; it.rs = rs; it.aop = aop; it.imm = imm; it.chk = chk;
        sb.push_back(it);
    endtask

    // Drive one cycle's inputs at the negedge, sample #1 later, advance to next negedge.
    task automatic cycle(input bit sel, input item_t it, output obs_t o);
        if (sel == 1'b0) begin
            ifa.op = it.op; ifa.mem_ready = it.mr; ifa.zero = it.zr;
        end else begin
            ifb.op = it.op; ifb.mem_ready = it.mr; ifb.zero = it.zr;
        end
        #1;
        if (sel == 1'b0) begin
            o = {ifa.state_dbg, ifa.mem_req, ifa.MemWrite, ifa.IRWrite, ifa.PCWrite, ifa.RegWrite,
                 ifa.illegal, ifa.ResultSrc, ifa.ALUOp, ifa.ImmSrc};
        end else begin
            o = {ifb.state_dbg, ifb.mem_req, ifb.MemWrite, ifb.IRWrite, ifb.PCWrite, ifb.RegWrite,
                 ifb.illegal, ifb.ResultSrc, ifb.ALUOp, ifb.ImmSrc};
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_na = 1'b0; rst_nb = 1'b0;
        ifa.op = 7'd0; ifa.mem_ready = 1'b1; ifa.zero = 1'b0;
        ifb.op = 7'd0; ifb.mem_ready = 1'b0; ifb.zero = 1'b0;
        #2;
        n_checks++;
        if ({ifa.state_dbg, ifa.illegal} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d ill=%b, want st=0 ill=0", ifa.state_dbg, ifa.illegal);
        end
        n_checks++;
        if ({ifa.mem_req, ifa.MemWrite, ifa.IRWrite, ifa.PCWrite, ifa.RegWrite} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b, want 00000",
                     {ifa.mem_req, ifa.MemWrite, ifa.IRWrite, ifa.PCWrite, ifa.RegWrite});
        end
        n_checks++;
        if ({ifa.AdrSrc, ifa.ResultSrc, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_selects: got %b, want 000000000",
                     {ifa.AdrSrc, ifa.ResultSrc, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp});
        end
        ifa.mem_ready = 1'b0;
        @(negedge clk);
        rst_na = 1'b1;
    endtask

    task automatic test_lw_wait();
        item_t it; obs_t o;
        add(OP_LOAD, 1'b0, 1'b0, 4'd0, 5'b10000, 1'b0, 2'b10, 2'b00, 3'b000, 2'b01);
        add(OP_LOAD, 1'b0, 1'b0, 4'd0, 5'b10000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_LOAD, 1'b1, 1'b0, 4'd0, 5'b10110, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_LOAD, 1'b0, 1'b0, 4'd1, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b10);
        add(OP_LOAD, 1'b0, 1'b0, 4'd2, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_LOAD, 1'b0, 1'b0, 4'd3, 5'b10000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b01);
        add(OP_LOAD, 1'b0, 1'b0, 4'd3, 5'b10000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_LOAD, 1'b1, 1'b0, 4'd3, 5'b10000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_LOAD, 1'b0, 1'b0, 4'd4, 5'b00001, 1'b0, 2'b01, 2'b00, 3'b000, 2'b01);
        add(OP_LOAD, 1'b0, 1'b0, 4'd0, 5'b10000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            it = sb.pop_front();
            cycle(1'b0, it, o);
            n_checks++;
            if ({o.st, o.strb, o.ill} !== {it.st, it.strb, it.ill}) begin
                n_fail++;
                $display("FAIL lw[%0d]: got st=%0d strb=%b ill=%b, want st=%0d strb=%b ill=%b",
                         i, o.st, o.strb, o.ill, it.st, it.strb, it.ill);
            end
            if (it.chk[0]) begin
                n_checks++;
                if ({o.rs, o.aop} !== {it.rs, it.aop}) begin
                    n_fail++;
                    $display("FAIL lw_mux[%0d]: got rs=%b aop=%b, want rs=%b aop=%b", i, o.rs, o.aop, it.rs, it.aop);
                end
            end
            if (it.chk[1]) begin
                n_checks++;
                if (o.imm !== it.imm) begin
                    n_fail++;
                    $display("FAIL lw_imm[%0d]: got %b, want %b", i, o.imm, it.imm);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        item_t it; obs_t o;
        for (int z = 1; z >= 0; z--) begin
            add(OP_BRANCH, 1'b1, z[0], 4'd0, 5'b10110, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
            add(OP_BRANCH, 1'b0, z[0], 4'd1, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b010, 2'b10);
            add(OP_BRANCH, 1'b0, z[0], 4'd9, {3'b000, z[0], 1'b0}, 1'b0, 2'b00, 2'b01, 3'b000, 2'b01);
        end
        add(OP_JALR, 1'b1, 1'b0, 4'd0,  5'b10110, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_JALR, 1'b0, 1'b0, 4'd1,  5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b10);
        add(OP_JALR, 1'b0, 1'b0, 4'd11, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b01);
        add(OP_JALR, 1'b0, 1'b0, 4'd10, 5'b00010, 1'b0, 2'b00, 2'b00, 3'b000, 2'b01);
        add(OP_JALR, 1'b0, 1'b0, 4'd8,  5'b00001, 1'b0, 2'b00, 2'b00, 3'b000, 2'b01);
        add(OP_JALR, 1'b0, 1'b0, 4'd0,  5'b10000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        for (int i = 0; i < 12 && sb.size() != 0; i++) begin
            it = sb.pop_front();
            cycle(1'b0, it, o);
            n_checks++;
            if ({o.st, o.strb, o.ill} !== {it.st, it.strb, it.ill}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got st=%0d strb=%b ill=%b, want st=%0d strb=%b ill=%b",
                         i, o.st, o.strb, o.ill, it.st, it.strb, it.ill);
            end
            if (it.chk[0]) begin
                n_checks++;
                if ({o.rs, o.aop} !== {it.rs, it.aop}) begin
                    n_fail++;
                    $display("FAIL b2b_mux[%0d]: got rs=%b aop=%b, want rs=%b aop=%b", i, o.rs, o.aop, it.rs, it.aop);
                end
            end
            if (it.chk[1]) begin
                n_checks++;
                if (o.imm !== it.imm) begin
                    n_fail++;
                    $display("FAIL b2b_imm[%0d]: got %b, want %b", i, o.imm, it.imm);
                end
            end
        end
    endtask

    task automatic test_trap();
        item_t it; obs_t o;
        add(7'b1111111, 1'b1, 1'b0, 4'd0, 5'b10110, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(7'b1111111, 1'b0, 1'b0, 4'd1, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b10);
        for (int k = 0; k < 20; k++) begin
            add(7'b1111111, k[0], 1'b1, 4'd14, 5'b00000, 1'b1, 2'b00, 2'b00, 3'b000, 2'b00);
        end
        for (int i = 0; i < 22 && sb.size() != 0; i++) begin
            it = sb.pop_front();
            cycle(1'b0, it, o);
            n_checks++;
            if ({o.st, o.strb, o.ill} !== {it.st, it.strb, it.ill}) begin
                n_fail++;
                $display("FAIL trap[%0d]: got st=%0d strb=%b ill=%b, want st=%0d strb=%b ill=%b",
                         i, o.st, o.strb, o.ill, it.st, it.strb, it.ill);
            end
            if (it.chk[1]) begin
                n_checks++;
                if (o.imm !== it.imm) begin
                    n_fail++;
                    $display("FAIL trap_imm[%0d]: got %b, want %b", i, o.imm, it.imm);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        item_t it; obs_t o;
        rst_na = 1'b0;
        @(negedge clk);
        rst_na = 1'b1;
        add(OP_STORE, 1'b1, 1'b0, 4'd0, 5'b10110, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_STORE, 1'b0, 1'b0, 4'd1, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b001, 2'b10);
        add(OP_STORE, 1'b0, 1'b0, 4'd2, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_STORE, 1'b0, 1'b0, 4'd5, 5'b11000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_STORE, 1'b0, 1'b0, 4'd5, 5'b11000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        for (int i = 0; i < 5 && sb.size() != 0; i++) begin
            it = sb.pop_front();
            if (sb.size() != 0) begin
                cycle(1'b0, it, o);
            end else begin
                ifa.mem_ready = it.mr;
                #1;
                o = {ifa.state_dbg, ifa.mem_req, ifa.MemWrite, ifa.IRWrite, ifa.PCWrite, ifa.RegWrite,
                     ifa.illegal, ifa.ResultSrc, ifa.ALUOp, ifa.ImmSrc};
            end
            n_checks++;
            if ({o.st, o.strb, o.ill} !== {it.st, it.strb, it.ill}) begin
                n_fail++;
                $display("FAIL sw_pre_reset[%0d]: got st=%0d strb=%b ill=%b, want st=%0d strb=%b ill=%b",
                         i, o.st, o.strb, o.ill, it.st, it.strb, it.ill);
            end
        end
        #2;
        rst_na = 1'b0;
        #1;
        n_checks++;
        if ({ifa.state_dbg, ifa.mem_req, ifa.MemWrite} !== {4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_write: got st=%0d mem_req=%b MemWrite=%b, want st=0 mem_req=0 MemWrite=0",
                     ifa.state_dbg, ifa.mem_req, ifa.MemWrite);
        end
        @(negedge clk);
        rst_na = 1'b1;
        #1;
        n_checks++;
        if ({ifa.state_dbg, ifa.mem_req, ifa.MemWrite, ifa.IRWrite} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset_release: got st=%0d mem_req=%b MemWrite=%b IRWrite=%b, want 0 1 0 0",
                     ifa.state_dbg, ifa.mem_req, ifa.MemWrite, ifa.IRWrite);
        end
        rst_na = 1'b0;
    endtask

    task automatic test_no_handshake();
        item_t it; obs_t o;
        add(OP_STORE, 1'b0, 1'b0, 4'd0, 5'b10110, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_STORE, 1'b0, 1'b0, 4'd1, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b001, 2'b10);
        add(OP_STORE, 1'b0, 1'b0, 4'd2, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_STORE, 1'b0, 1'b0, 4'd5, 5'b11000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_LUI,   1'b0, 1'b0, 4'd0, 5'b10110, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_LUI,   1'b0, 1'b0, 4'd1, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b100, 2'b10);
        add(OP_LUI,   1'b0, 1'b0, 4'd12, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b01);
        add(OP_LUI,   1'b0, 1'b0, 4'd8, 5'b00001, 1'b0, 2'b00, 2'b00, 3'b000, 2'b01);
        add(OP_AUIPC, 1'b0, 1'b0, 4'd0, 5'b10110, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_AUIPC, 1'b0, 1'b0, 4'd1, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b100, 2'b10);
        add(OP_AUIPC, 1'b0, 1'b0, 4'd13, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(OP_AUIPC, 1'b0, 1'b0, 4'd8, 5'b00001, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(7'b1111111, 1'b0, 1'b0, 4'd0, 5'b10110, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        add(7'b1111111, 1'b0, 1'b0, 4'd1, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000, 2'b10);
        add(7'b1111111, 1'b0, 1'b0, 4'd0, 5'b10110, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00);
        @(negedge clk);
        rst_nb = 1'b1;
        for (int i = 0; i < 15 && sb.size() != 0; i++) begin
            it = sb.pop_front();
            cycle(1'b1, it, o);
            n_checks++;
            if ({o.st, o.strb, o.ill} !== {it.st, it.strb, it.ill}) begin
                n_fail++;
                $display("FAIL nohs[%0d]: got st=%0d strb=%b ill=%b, want st=%0d strb=%b ill=%b",
                         i, o.st, o.strb, o.ill, it.st, it.strb, it.ill);
            end
            if (it.chk[0]) begin
                n_checks++;
                if ({o.rs, o.aop} !== {it.rs, it.aop}) begin
                    n_fail++;
                    $display("FAIL nohs_mux[%0d]: got rs=%b aop=%b, want rs=%b aop=%b", i, o.rs, o.aop, it.rs, it.aop);
                end
            end
            if (it.chk[1]) begin
                n_checks++;
                if (o.imm !== it.imm) begin
                    n_fail++;
                    $display("FAIL nohs_imm[%0d]: got %b, want %b", i, o.imm, it.imm);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL nohs_drain: got %0d items left, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_back_to_back();
        test_trap();
        test_reset_mid_write();
        test_no_handshake();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
